// File: rtl/uart_loop_engine_if.sv
// UART FIFO-side bundle for uart_loop_engine.
// master: the engine (pops RX, pushes TX); slave: the FIFO pair / board side.
interface uart_loop_engine_if #(
  parameter int DBIT = 8
);
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            tx_full;
  logic            rd_uart;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, wr_uart, w_data
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, wr_uart, w_data
  );
endinterface

// File: rtl/uart_loop_engine.sv
// uart_loop_engine: pops bytes from the UART RX FIFO, transforms them
// (echo / add INC_STEP / invert) and pushes them to the TX FIFO, or emits a
// burst of BURST_LEN bytes seeded from the last received byte.
// Runs on step_tick, or continuously while auto_en is high.
// Optional feature macro: UART_LOOP_TIMEOUT_EN -- abandons a push (or the rest
// of a burst) after TX_TIMEOUT cycles of tx_full and counts the dropped bytes.
// Without it the engine waits on tx_full forever and drop_count stays 0.
module uart_loop_engine #(
  parameter int DBIT       = 8,
  parameter int INC_STEP   = 1,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 16,
  parameter int TX_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_loop_engine_if.master    fifo,
  input  logic [1:0]            mode,
  input  logic                  auto_en,
  input  logic                  step_tick,
  output logic [DBIT-1:0]       last_rx,
  output logic [CNT_W-1:0]      rx_count,
  output logic [CNT_W-1:0]      tx_count,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, POP, XFORM, PUSH, BURST} state_t;
  typedef enum logic [1:0] {MODE_ECHO, MODE_ADD, MODE_INV, MODE_BURST} mode_t;

  state_t          state;
  mode_t           mode_q;
  logic [7:0]      idx;
  logic [DBIT-1:0] xform_data;
  logic            go;
  logic            timeout_hit;

  assign go   = auto_en | step_tick;
  assign busy = (state != IDLE);

`ifdef UART_LOOP_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TX_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign timeout_hit = fifo.tx_full && (wait_cnt == WAIT_W'(TX_TIMEOUT - 1));

  // Count consecutive blocked cycles while a byte is waiting for TX space.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (fifo.tx_full &&
                 ((state == PUSH && !fifo.wr_uart) || state == BURST)) begin
      wait_cnt <= timeout_hit ? '0 : wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TX_TIMEOUT != 0);
`endif

  // Byte transform selected by the mode latched at transaction start.
  always_comb begin
    // NOTE: default assignment first so no path leaves xform_data unassigned (no latch).
    xform_data = last_rx;
    case (mode_q)
      MODE_ADD: xform_data = last_rx + DBIT'(INC_STEP);
      MODE_INV: xform_data = ~last_rx;
      default:  ;
    endcase
  end

  // Transaction FSM; strobes are registered and default low each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      mode_q        <= MODE_ECHO;
      idx           <= '0;
      fifo.rd_uart  <= 1'b0;
      fifo.wr_uart  <= 1'b0;
      fifo.w_data   <= '0;
      last_rx       <= '0;
      rx_count      <= '0;
      tx_count      <= '0;
      drop_count    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
      fifo.rd_uart <= 1'b0;
      fifo.wr_uart <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            if (mode_t'(mode) == MODE_BURST) begin
              mode_q <= MODE_BURST;
              idx    <= '0;
              state  <= BURST;
            end else if (!fifo.rx_empty) begin
              // Pop strobe and capture coincide: the head byte is taken exactly once.
              mode_q       <= mode_t'(mode);
              fifo.rd_uart <= 1'b1;
              last_rx      <= fifo.r_data;
              rx_count     <= rx_count + 1'b1;
              state        <= POP;
            end
          end
        end
        POP: state <= XFORM;
        XFORM: begin
          // Push is decided here so wr_uart lands 3 cycles after the tick.
          fifo.w_data <= xform_data;
          state       <= PUSH;
          if (!fifo.tx_full) begin
            fifo.wr_uart <= 1'b1;
            tx_count     <= tx_count + 1'b1;
          end
        end
        PUSH: begin
          if (fifo.wr_uart) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            drop_count <= drop_count + 1'b1;
            state      <= IDLE;
          end else if (!fifo.tx_full) begin
            fifo.wr_uart <= 1'b1;
            tx_count     <= tx_count + 1'b1;
          end
        end
        BURST: begin
          if (timeout_hit) begin
            drop_count <= drop_count + CNT_W'(BURST_LEN) - CNT_W'(idx);
            state      <= IDLE;
          end else if (!fifo.tx_full) begin
            fifo.wr_uart <= 1'b1;
            fifo.w_data  <= last_rx + DBIT'(idx);
            tx_count     <= tx_count + 1'b1;
            idx          <= idx + 1'b1;
            if (idx == 8'(BURST_LEN - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loop_engine.sv
// Bench for uart_loop_engine: two instances (INC_STEP=1 and INC_STEP=3) share
// the same FIFO stimulus. RX FIFO and TX sink are modelled with queues;
// expectations come from constant tables and a byte-level reference model.
module tb_uart_loop_engine;
  localparam int DBIT       = 8;
  localparam int BURST_LEN  = 4;
  localparam int CNT_W      = 16;
  localparam int TX_TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mode = 2'd0;
  logic       auto_en = 1'b0;
  logic       step_tick = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       tx_full = 1'b0;

  uart_loop_engine_if #(.DBIT(DBIT)) bus_a ();
  uart_loop_engine_if #(.DBIT(DBIT)) bus_b ();
  assign bus_a.rx_empty = rx_empty;
  assign bus_a.r_data   = r_data;
  assign bus_a.tx_full  = tx_full;
  assign bus_b.rx_empty = rx_empty;
  assign bus_b.r_data   = r_data;
  assign bus_b.tx_full  = tx_full;

  logic [7:0]       last_a, last_b;
  logic [CNT_W-1:0] rxc_a, txc_a, drop_a, rxc_b, txc_b, drop_b;
  logic             busy_a, busy_b;

  uart_loop_engine #(.DBIT(DBIT), .INC_STEP(1), .BURST_LEN(BURST_LEN),
                     .CNT_W(CNT_W), .TX_TIMEOUT(TX_TIMEOUT)) dut_a (
    .clk(clk), .reset(reset), .fifo(bus_a), .mode(mode), .auto_en(auto_en),
    .step_tick(step_tick), .last_rx(last_a), .rx_count(rxc_a), .tx_count(txc_a),
    .drop_count(drop_a), .busy(busy_a));

  uart_loop_engine #(.DBIT(DBIT), .INC_STEP(3), .BURST_LEN(BURST_LEN),
                     .CNT_W(CNT_W), .TX_TIMEOUT(TX_TIMEOUT)) dut_b (
    .clk(clk), .reset(reset), .fifo(bus_b), .mode(mode), .auto_en(auto_en),
    .step_tick(step_tick), .last_rx(last_b), .rx_count(rxc_b), .tx_count(txc_b),
    .drop_count(drop_b), .busy(busy_b));

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc_no = 0;
  int         pops_a = 0;
  int         pops_b = 0;
  int         full_run = 0;
  bit         rand_full = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] txa[$];
  logic [7:0] txb[$];
  int         push_cyc[$];

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void upd_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  endfunction

  // Advance one clock; sample just after the edge, model FIFOs, drive inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_no++;
    if (bus_a.rd_uart) begin
      pops_a++;
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    if (bus_b.rd_uart) pops_b++;
    if (bus_a.wr_uart) begin
      txa.push_back(bus_a.w_data);
      push_cyc.push_back(cyc_no);
    end
    if (bus_b.wr_uart) txb.push_back(bus_b.w_data);
    upd_rx();
    if (rand_full) begin
      tx_full  = (full_run >= 3) ? 1'b0 : 1'($urandom_range(0, 1));
      full_run = tx_full ? full_run + 1 : 0;
    end
  endtask

  task automatic pulse();
    step_tick = 1'b1;
    cyc();
    step_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy_a && n < budget) begin
      cyc();
      n++;
    end
    if (busy_a) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic clear_logs();
    txa.delete();
    txb.delete();
    push_cyc.delete();
    pops_a = 0;
    pops_b = 0;
  endtask

  function automatic logic [7:0] model(input int m, input logic [7:0] b, input int inc);
    case (m)
      0:       return b;
      1:       return 8'((int'(b) + inc) % 256);
      default: return 8'(255 - int'(b));
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t             vt[7];
    logic [7:0]       burst_exp[4];
    logic [7:0]       expa[$];
    logic [7:0]       expb[$];
    logic [7:0]       model_last;
    logic [CNT_W-1:0] rc0, tc0;
    int               n;

    vt[0] = '{2'd0, 8'h41, 8'h41, 8'h41};
    vt[1] = '{2'd1, 8'hFF, 8'h00, 8'h02};
    vt[2] = '{2'd1, 8'h10, 8'h11, 8'h13};
    vt[3] = '{2'd2, 8'h0F, 8'hF0, 8'hF0};
    vt[4] = '{2'd1, 8'h7F, 8'h80, 8'h82};
    vt[5] = '{2'd2, 8'h00, 8'hFF, 8'hFF};
    vt[6] = '{2'd0, 8'hA5, 8'hA5, 8'hA5};
    burst_exp[0] = 8'hFE;
    burst_exp[1] = 8'hFF;
    burst_exp[2] = 8'h00;
    burst_exp[3] = 8'h01;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_strobes", {bus_a.rd_uart, bus_a.wr_uart}, 0);
    check("rst_wdata", bus_a.w_data, 0);
    check("rst_last_rx", last_a, 0);
    check("rst_counts", {rxc_a, txc_a, drop_a}, 0);
    reset = 1'b1;
    cyc();

    // Echo, manual step: rd_uart at +1, wr_uart at +3
    clear_logs();
    mode = 2'd0;
    rxq.push_back(8'h41);
    upd_rx();
    pulse();
    check("echo_rd_at_1", bus_a.rd_uart, 1);
    cyc();
    check("echo_rd_at_2", bus_a.rd_uart, 0);
    check("echo_wr_at_2", bus_a.wr_uart, 0);
    cyc();
    check("echo_wr_at_3", bus_a.wr_uart, 1);
    check("echo_wdata", bus_a.w_data, 8'h41);
    wait_idle("echo_idle", 10);
    check("echo_rx_count", rxc_a, 1);
    check("echo_tx_count", txc_a, 1);
    rxq.push_back(8'h42);
    upd_rx();
    repeat (8) cyc();
    check("echo_no_second_pop", pops_a, 1);
    rxq.delete();
    upd_rx();

    // Table of single transactions on both INC_STEP instances
    for (int i = 0; i < 7; i++) begin
      clear_logs();
      mode = vt[i].mode;
      rxq.push_back(vt[i].din);
      upd_rx();
      pulse();
      wait_idle("vec_idle", 20);
      check($sformatf("vec%0d_npush", i), txa.size(), 1);
      check($sformatf("vec%0d_a", i), (txa.size() > 0) ? txa[0] : 8'hxx, vt[i].exp_a);
      check($sformatf("vec%0d_b", i), (txb.size() > 0) ? txb[0] : 8'hxx, vt[i].exp_b);
    end

    // Backpressure in invert mode
    clear_logs();
    mode = 2'd2;
    tx_full = 1'b1;
    rxq.push_back(8'h0F);
    upd_rx();
    pulse();
    repeat (13) cyc();
    check("bp_held", txa.size(), 0);
    tx_full = 1'b0;
    repeat (6) cyc();
    check("bp_idle", busy_a, 0);
`ifdef UART_LOOP_TIMEOUT_EN
    check("bp_npush", txa.size(), 0);
    check("bp_drop", drop_a, 1);
`else
    check("bp_npush", txa.size(), 1);
    check("bp_wdata", (txa.size() > 0) ? txa[0] : 8'hxx, 8'hF0);
    check("bp_drop", drop_a, 0);
`endif

    // Burst seeded from last_rx = FE with tx_full toggling
    clear_logs();
    mode = 2'd0;
    rxq.push_back(8'hFE);
    upd_rx();
    pulse();
    wait_idle("burst_seed", 20);
    clear_logs();
    tc0 = txc_a;
    mode = 2'd3;
    tx_full = 1'b1;
    pulse();
    n = 0;
    while (busy_a && n < 40) begin
      tx_full = ~tx_full;
      cyc();
      n++;
    end
    tx_full = 1'b0;
    check("burst_bounded", busy_a, 0);
    check("burst_npush", txa.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("burst_byte%0d", i), (i < txa.size()) ? txa[i] : 8'hxx, burst_exp[i]);
    check("burst_no_pop", pops_a, 0);
    check("burst_tx_count", 16'(txc_a - tc0), 4);

    // Auto stream: 5 bytes, one per 4 cycles
    clear_logs();
    mode = 2'd0;
    for (int i = 0; i < 5; i++) rxq.push_back(8'(8'h10 + 8'h11 * i));
    upd_rx();
    auto_en = 1'b1;
    n = 0;
    while ((rxq.size() > 0 || busy_a) && n < 60) begin
      cyc();
      n++;
    end
    auto_en = 1'b0;
    check("auto_pops", pops_a, 5);
    check("auto_pops_b", pops_b, 5);
    check("auto_npush", txa.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("auto_byte%0d", i), (i < txa.size()) ? txa[i] : 8'hxx, 8'(8'h10 + 8'h11 * i));
    for (int i = 1; i < 5; i++)
      check($sformatf("auto_gap%0d", i), (i < push_cyc.size()) ? push_cyc[i] - push_cyc[i-1] : -1, 4);
    check("auto_end_state", {rx_empty, busy_a}, 2'b10);

    // Randomized segments against the byte-level model
    model_last = 8'h10 + 8'h11 * 4;
    rand_full = 1'b1;
    for (int seg = 0; seg < 30; seg++) begin
      int m, npop;
      m = $urandom_range(0, 3);
      clear_logs();
      expa.delete();
      expb.delete();
      rc0 = rxc_a;
      tc0 = txc_a;
      npop = 0;
      if (m == 3) begin
        mode = 2'd3;
        for (int j = 0; j < $urandom_range(1, 3); j++) begin
          pulse();
          wait_idle("rnd_burst", 40);
          for (int q = 0; q < BURST_LEN; q++) begin
            expa.push_back(8'((int'(model_last) + q) % 256));
            expb.push_back(8'((int'(model_last) + q) % 256));
          end
        end
      end else begin
        npop = $urandom_range(1, 6);
        mode = 2'(m);
        for (int j = 0; j < npop; j++) begin
          logic [7:0] b;
          b = 8'($urandom);
          rxq.push_back(b);
          expa.push_back(model(m, b, 1));
          expb.push_back(model(m, b, 3));
          model_last = b;
        end
        upd_rx();
        if ($urandom_range(0, 1) == 1) begin
          auto_en = 1'b1;
          n = 0;
          while ((rxq.size() > 0 || busy_a) && n < 200) begin
            cyc();
            n++;
          end
          auto_en = 1'b0;
          wait_idle("rnd_auto", 10);
        end else begin
          for (int j = 0; j < npop; j++) begin
            pulse();
            wait_idle("rnd_step", 30);
          end
        end
      end
      check($sformatf("rnd%0d_npush", seg), txa.size(), expa.size());
      for (int i = 0; i < expa.size(); i++) begin
        check($sformatf("rnd%0d_a%0d", seg, i), (i < txa.size()) ? txa[i] : 8'hxx, expa[i]);
        check($sformatf("rnd%0d_b%0d", seg, i), (i < txb.size()) ? txb[i] : 8'hxx, expb[i]);
      end
      check($sformatf("rnd%0d_rxcnt", seg), 16'(rxc_a - rc0), npop);
      check($sformatf("rnd%0d_txcnt", seg), 16'(txc_a - tc0), expa.size());
    end
    rand_full = 1'b0;
    tx_full = 1'b0;

    // Asynchronous reset in the middle of a burst
    clear_logs();
    mode = 2'd3;
    pulse();
    cyc();
    cyc();
    check("mrst_busy_pre", busy_a, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_busy", busy_a, 0);
    check("mrst_strobes", {bus_a.rd_uart, bus_a.wr_uart}, 0);
    check("mrst_data", {bus_a.w_data, last_a}, 0);
    check("mrst_counts", {rxc_a, txc_a, drop_a}, 0);
    mode = 2'd0;
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    repeat (8) cyc();
    check("mrst_no_retry", txa.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
